// File: rtl/pad_reader.sv
// rtl/pad_reader.sv - NES-style pad serial reader; optional PAD_EDGE_EN macro adds press-edge output
module pad_reader #(
    parameter int LATCH_CYCLES = 1200,
    parameter int HALF_CYCLES  = 600,
    parameter int POLL_CYCLES  = 1666667
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pad_data,
    output logic       pad_latch,
    output logic       pad_clk,
    output logic [7:0] buttons,
    output logic       buttons_valid,
    output logic [7:0] buttons_pressed
);

    // The phase counter is shared by LATCH and both pad_clk halves, so it is
    // sized for the longer of the two durations.
    localparam int PHASE_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
    localparam int PHASE_W   = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;
    localparam int POLL_W    = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

    localparam logic [PHASE_W-1:0] LATCH_LAST = PHASE_W'(LATCH_CYCLES - 1);
    localparam logic [PHASE_W-1:0] HALF_LAST  = PHASE_W'(HALF_CYCLES - 1);
    localparam logic [POLL_W-1:0]  POLL_LAST  = POLL_W'(POLL_CYCLES - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LATCH  = 3'd1;
    localparam logic [2:0] CLK_LO = 3'd2;
    localparam logic [2:0] CLK_HI = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    logic [2:0]         state;
    logic [PHASE_W-1:0] phase_cnt;
    logic [POLL_W-1:0]  poll_cnt;
    logic [2:0]         bit_idx;
    logic [7:0]         shift_q;
    logic [1:0]         sync_q;
    logic               data_s;
    logic               poll_wrap;

    assign data_s    = sync_q[1];
    assign poll_wrap = (poll_cnt == POLL_LAST);

    // Pad strobes are decoded straight from the state register.
    assign pad_latch = (state == LATCH);
    assign pad_clk   = (state == CLK_HI);

    // Two-flop synchronizer; resets to the idle (released) level of the line.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], pad_data};
        end
    end

    // Free-running poll counter; starting at the wrap value makes the first
    // frame begin right after reset is released.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            poll_cnt <= POLL_LAST;
        end else if (poll_wrap) begin
            poll_cnt <= '0;
        end else begin
            poll_cnt <= poll_cnt + POLL_W'(1);
        end
    end

    // Frame sequencer: latch pulse, then eight low/high pad_clk phases.
    // Each bit is sampled at the end of its low phase, after the pad output
    // has had a full half-period to settle through the synchronizer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            phase_cnt <= '0;
            bit_idx   <= '0;
            shift_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    phase_cnt <= '0;
                    if (poll_wrap) begin
                        state <= LATCH;
                    end
                end
                LATCH: begin
                    if (phase_cnt == LATCH_LAST) begin
                        state     <= CLK_LO;
                        phase_cnt <= '0;
                        bit_idx   <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + PHASE_W'(1);
                    end
                end
                CLK_LO: begin
                    if (phase_cnt == HALF_LAST) begin
                        shift_q[bit_idx] <= ~data_s;
                        phase_cnt        <= '0;
                        state            <= (bit_idx == 3'd7) ? DONE : CLK_HI;
                    end else begin
                        phase_cnt <= phase_cnt + PHASE_W'(1);
                    end
                end
                CLK_HI: begin
                    if (phase_cnt == HALF_LAST) begin
                        phase_cnt <= '0;
                        bit_idx   <= bit_idx + 3'd1;
                        state     <= CLK_LO;
                    end else begin
                        phase_cnt <= phase_cnt + PHASE_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Whole-frame update of the visible button state plus its strobe.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            buttons       <= 8'h00;
            buttons_valid <= 1'b0;
        end else begin
            buttons_valid <= (state == DONE);
            if (state == DONE) begin
                buttons <= shift_q;
            end
        end
    end

`ifdef PAD_EDGE_EN
    logic [7:0] pressed_q;

    // Newly pressed buttons, compared against the state being replaced.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pressed_q <= 8'h00;
        end else if (state == DONE) begin
            pressed_q <= shift_q & ~buttons;
        end else begin
            pressed_q <= 8'h00;
        end
    end

    assign buttons_pressed = pressed_q;
`else
    assign buttons_pressed = 8'h00;
`endif

endmodule

// File: tb/tb_pad_reader.sv
// tb/tb_pad_reader.sv - randomized self-checking bench for pad_reader against a pad model
module tb_pad_reader;

    localparam int LATCH = 4;
    localparam int HALF  = 4;
    localparam int POLL  = 100;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pad_data;
    logic       pad_latch;
    logic       pad_clk;
    logic [7:0] buttons;
    logic       buttons_valid;
    logic [7:0] buttons_pressed;

    pad_reader #(
        .LATCH_CYCLES(LATCH),
        .HALF_CYCLES (HALF),
        .POLL_CYCLES (POLL)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .pad_data       (pad_data),
        .pad_latch      (pad_latch),
        .pad_clk        (pad_clk),
        .buttons        (buttons),
        .buttons_valid  (buttons_valid),
        .buttons_pressed(buttons_pressed)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Pad model: parallel load on latch, shift toward bit0 on each pad_clk rise.
    logic [7:0] pad_pat = 8'h00;
    logic       plugged = 1'b1;
    logic [7:0] pad_sr  = 8'hFF;

    always @(posedge pad_latch or posedge pad_clk) begin
        if (pad_latch) pad_sr <= ~pad_pat;
        else           pad_sr <= {1'b1, pad_sr[7:1]};
    end

    assign pad_data = plugged ? pad_sr[0] : 1'b1;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: last frame's expected buttons and latch-start bookkeeping.
    logic [7:0] prev_b     = 8'h00;
    int         last_start = 0;
    bit         have_last  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic run_frame(input logic [7:0] pat, input bit plug);
        int         n;
        int         rises;
        int         hi_run;
        logic       prev_clk;
        logic [7:0] exp_b;
        logic [7:0] exp_p;
        pad_pat = pat;
        plugged = plug;
        exp_b   = plug ? pat : 8'h00;
        n = 0;
        @(negedge clk);
        while (!pad_latch && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!pad_latch) begin
            check("latch_timeout", 0, 1);
            return;
        end
        if (have_last) check("latch_spacing", cyc - last_start, POLL);
        last_start = cyc;
        have_last  = 1'b1;
        n = 0;
        while (pad_latch && n < 300) begin
            n++;
            @(negedge clk);
        end
        check("latch_width", n, LATCH);
        rises = 0; hi_run = 0; prev_clk = 1'b0; n = 0;
        while (!buttons_valid && n < 300) begin
            check("buttons_hold", buttons, prev_b);
            if (pad_clk) hi_run++;
            if (pad_clk && !prev_clk) rises++;
            if (!pad_clk && prev_clk) begin
                check("clk_high_width", hi_run, HALF);
                hi_run = 0;
            end
            prev_clk = pad_clk;
            @(negedge clk);
            n++;
        end
        if (!buttons_valid) begin
            check("valid_timeout", 0, 1);
            return;
        end
        check("clk_rises", rises, 7);
        check("buttons", buttons, exp_b);
`ifdef PAD_EDGE_EN
        exp_p = exp_b & ~prev_b;
`else
        exp_p = 8'h00;
`endif
        check("pressed", buttons_pressed, exp_p);
        prev_b = exp_b;
        @(negedge clk);
        check("valid_width", buttons_valid, 0);
        check("pressed_clear", buttons_pressed, 0);
        check("buttons_after", buttons, exp_b);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_latch"}, pad_latch, 0);
        check({tag, "_clk"}, pad_clk, 0);
        check({tag, "_buttons"}, buttons, 8'h00);
        check({tag, "_valid"}, buttons_valid, 0);
        check({tag, "_pressed"}, buttons_pressed, 8'h00);
    endtask

    // Abort a frame during the high phase of bit 3 (the 4th pad_clk rise).
    task automatic reset_mid_frame(input logic [7:0] next_pat);
        int   n;
        int   rises;
        logic prev_clk;
        n = 0;
        @(negedge clk);
        while (!pad_latch && n < 300) begin
            @(negedge clk);
            n++;
        end
        rises = 0; prev_clk = 1'b0; n = 0;
        while (rises < 4 && n < 300) begin
            if (pad_clk && !prev_clk) rises++;
            prev_clk = pad_clk;
            if (rises < 4) begin
                @(negedge clk);
                n++;
            end
        end
        check("midrst_reach_bit3", rises, 4);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("midrst");
        repeat (3) begin
            @(negedge clk);
            check("midrst_no_valid", buttons_valid, 0);
        end
        prev_b    = 8'h00;
        have_last = 1'b0;
        pad_pat   = next_pat;
        plugged   = 1'b1;
        reset_n   = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_latch_restart", pad_latch, 1);
    endtask

    initial begin
        logic [7:0] rpat;
        reset_n = 1'b0;
        pad_pat = 8'h81;
        plugged = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_latch", pad_latch, 1);

        run_frame(8'h81, 1'b1);
        repeat (3) run_frame(8'($urandom), 1'b0);
        run_frame(8'h01, 1'b1);
        run_frame(8'h03, 1'b1);
        run_frame(8'h03, 1'b1);
        run_frame(8'hA5, 1'b1);

        rpat = 8'($urandom);
        reset_mid_frame(rpat);
        run_frame(rpat, 1'b1);

        for (int i = 0; i < 8; i++) begin
            run_frame(8'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pad_reader.md
PAD_READER -- requirements
Module: pad_reader

Interface
REQ-001 Parameter LATCH_CYCLES, default 1200, SHALL set the pad_latch high time in clk cycles (12 us at 100 MHz).
REQ-002 Parameter HALF_CYCLES, default 600, SHALL set each pad_clk half-period in clk cycles (min 4).
REQ-003 Parameter POLL_CYCLES, default 1666667, SHALL set the period from one latch start to the next (must exceed LATCH_CYCLES+15*HALF_CYCLES+4).
REQ-004 clk  input  1  system clock; all logic on its rising edge, no other clock.
REQ-005 reset_n  input  1  synchronous reset, active-low, sampled on rising clk.
REQ-006 pad_data  input  1  serial data from NES-style pad, active-low (0 = pressed), asynchronous to clk.
REQ-007 pad_latch  output  1  latch strobe to pad, active-high.
REQ-008 pad_clk  output  1  shift clock to pad; pad advances on its rising edge.
REQ-009 buttons  output  8  registered button state, active-high; bit0..7 = A, B, Select, Start, Up, Down, Left, Right.
REQ-010 buttons_valid  output  1  one-cycle pulse when buttons updates.
REQ-011 buttons_pressed  output  8  one-cycle per-bit pulse on a 0->1 button transition (see Configuration).

Function
REQ-012 pad_data SHALL pass through a 2-flop synchronizer; all sampling SHALL use the synchronized value.
REQ-013 FSM states SHALL be IDLE, LATCH, CLK_LO, CLK_HI, DONE.
REQ-014 IDLE: pad_latch=0, pad_clk=0; on poll counter reaching POLL_CYCLES-1 SHALL restart the counter and enter LATCH.
REQ-015 LATCH: pad_latch=1 for exactly LATCH_CYCLES cycles, then CLK_LO with bit index 0.
REQ-016 CLK_LO: pad_clk=0 for HALF_CYCLES cycles; on the last cycle SHALL store inverted synchronized data into shift bit[index].
REQ-017 From CLK_LO: index<7 -> CLK_HI; index=7 -> DONE.
REQ-018 CLK_HI: pad_clk=1 for HALF_CYCLES cycles, then index+1 and CLK_LO.
REQ-019 DONE: one cycle; buttons SHALL load the 8 collected bits and buttons_valid SHALL be 1 in the following cycle only; then IDLE.
REQ-020 A frame SHALL therefore contain exactly 7 pad_clk rising edges and 8 samples.
REQ-021 Poll counter SHALL run continuously in all states, free of FSM state, wrapping at POLL_CYCLES-1 to 0, so latch starts are exactly POLL_CYCLES apart.
REQ-022 Phase counters SHALL be wide enough for each parameter; no truncation.
REQ-023 buttons SHALL hold its value between frames; a frame is never partially applied.
REQ-024 pad_data held at 1 (pad unplugged) SHALL yield buttons=8'h00.

Reset
REQ-025 While reset_n=0 at a clk edge: state=IDLE, poll counter=POLL_CYCLES-1, index=0, shift=0, synchronizer=2'b11.
REQ-026 Reset values: pad_latch=0, pad_clk=0, buttons=8'h00, buttons_valid=0, buttons_pressed=8'h00.
REQ-027 First clk edge with reset_n=1 SHALL enter LATCH (pad_latch high in the next cycle).
REQ-028 Reset asserted mid-frame SHALL abort the frame with no buttons_valid pulse and no buttons update.

Configuration
REQ-029 Macro PAD_EDGE_EN defined: buttons_pressed SHALL equal new buttons & ~previous buttons, asserted in the same cycle as buttons_valid, else 0.
REQ-030 Macro PAD_EDGE_EN undefined: buttons_pressed SHALL be constant 8'h00 and no edge register SHALL exist.

Verification
(bench parameters LATCH_CYCLES=4, HALF_CYCLES=4, POLL_CYCLES=100)
REQ-031 Release reset, pad model returns A and Right pressed -> latch high 4 cycles, 7 pad_clk pulses of 4/4, buttons=8'h81 with a one-cycle buttons_valid.
REQ-032 pad_data stuck 1 for 3 frames -> buttons=8'h00 each frame, buttons_valid every 100 cycles, latch rises exactly 100 cycles apart.
REQ-033 With PAD_EDGE_EN, frame1 8'h01, frame2 8'h03, frame3 8'h03 -> buttons_pressed 8'h01, 8'h02, 8'h00 on the respective valid cycles; without the macro, always 8'h00.
REQ-034 Assert reset_n=0 during CLK_HI of bit 3 -> outputs at reset values next cycle, no valid pulse; after release, full new frame starting with latch.
REQ-035 Pad model sampling data on each pad_clk rising edge, pattern 8'hA5 -> buttons=8'hA5, confirming bit order A..Right = bit0..bit7.
